rs_age_queue: RTL and testbench
===============================

# rs_age_queue

Parametrised reservation station: the successor to the single-ALU-port RS. It accepts decoded ALU instructions from the decoder and holds them until both operands are available. It snoops `N_CDB` result broadcast channels, including a same-cycle bypass into the entry being issued, and dispatches the **oldest** ready entry to the ALU over a valid/ready handshake. All state is flushed on `rollback`.

## Interface
- `DEPTH`, 16: number of entries (power of two, ≥2).
- `ROB_POS_W`, 4: ROB position width. Operand tag width is `ROB_POS_W+1`. Tag MSB=1 means pending on ROB position `tag[ROB_POS_W-1:0]`; MSB=0 means the value is present.
- `DATA_W`, 32: operand/immediate/PC width.
- `N_CDB`, 2: number of broadcast channels (ALU, LSB, …).
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable. When low, all state holds and `rollback`/issue are ignored. `rst` still acts.
- `rollback` in 1: flush, synchronous.
- `full` out 1: combinational; the decoder must not issue while it is high.
- `count` out `$clog2(DEPTH)+1`: number of busy entries (registered).
- `issue_valid` in 1; `issue_rob_pos` in `ROB_POS_W`; `issue_opcode` in 7; `issue_func3` in 3; `issue_func1` in 1.
- `issue_rs1_val`, `issue_rs2_val`, `issue_imm`, `issue_pc` in `DATA_W`; `issue_rs1_tag`, `issue_rs2_tag` in `ROB_POS_W+1`.
- `out_valid` out 1; `out_ready` in 1. `out_opcode`, `out_func3`, `out_func1`, `out_val1`, `out_val2`, `out_imm`, `out_pc`, `out_rob_pos` out: the registered dispatch payload.
- `cdb_valid` in `N_CDB`; `cdb_rob_pos` in `N_CDB*ROB_POS_W`; `cdb_val` in `N_CDB*DATA_W`. Channel k occupies slice k.

## Operation
- **Entry state:** busy, opcode/func fields, two (tag, val) pairs, imm, pc, rob_pos, and an age row.
- **Ready:** an entry is ready when it is busy and both tag MSBs are 0.
- **`full`:** `(free==0) || (free==1 && issue_valid)`.
- **Issue:**
  - Issue is accepted when `issue_valid && rdy && !rollback`. It writes the lowest-index free entry.
  - Issue while no entry is free is dropped. The bench flags this as an error.
- **Issue bypass:** if an issued operand tag is pending and matches a valid CDB channel in the same cycle, the entry stores that channel's value and a cleared tag.
- **Wakeup:** for each busy entry operand with a pending tag matching `{1, cdb_rob_pos[k]}` with `cdb_valid[k]`, load `cdb_val[k]` and clear the tag to 0. On multiple simultaneous matches, the lowest k wins.
- **Age matrix:**
  - On allocating entry e, `older[e][j] = busy[j]` for all j (excluding any entry dispatched in the same cycle). Column e is cleared in all other rows.
  - Selected entry = ready and no ready entry j with `older[e][j]`.
- **Dispatch:**
  - Dispatch happens when a ready entry exists and (`!out_valid || out_ready`).
  - The payload is loaded into the `out_*` registers, `out_valid` is set to 1, and the entry's busy bit is cleared, all on the same edge.
  - If nothing is selected and `out_ready`, `out_valid` goes to 0.
  - While `out_valid && !out_ready`, the payload and `out_valid` hold unchanged.
- **Freed-slot reuse:** a slot freed by dispatch is reusable by issue on the next cycle only. Issue picks from busy==0 as sampled at the current edge.
- **Rollback/reset:** all busy bits = 0, `out_valid`=0, `count`=0, and age rows cleared, all at the next edge. Same-cycle issue and CDB are discarded.
- **Output reset values:** `out_valid`=0, `count`=0, `out_*` payload=0, `full`=0.

## Timing
- Issue at edge t → entry busy after t. If the entry is ready at issue, `out_valid` rises after edge t+1. Minimum latency is 2 cycles.
- CDB at edge t wakes an entry → the entry is eligible for selection at edge t+1.
- Throughput: one dispatch per cycle with `out_ready` held high.
- `count` updates at the same edge as busy: +1 on issue, −1 on dispatch, net 0 when both happen.
- `rdy` low: no state change, including the output hold; `out_valid` stays as is.

## Structure
- Shared package `rs_pkg`:
  - tag pending-bit position;
  - `TAG_W = ROB_POS_W+1`;
  - opcode/func3 width constants (shared with decoder/ALU);
  - "no position" constant for empty selectors.
- One sub-module, `rs_age_select`: `DEPTH`-wide ready vector plus age matrix → one-hot grant and `any`.
- Free-slot priority encoding and CDB compare stay in `rs_age_queue`.

## Test plan
- **Oldest-first:** issue A (rs1 tag `{1,3}`), then B (ready), then C (ready). CDB ROB 3 = 0x55 → B dispatched, then C, then A with `out_val1`=0x55. Dispatch order by age, not index.
- **Issue bypass:** issue with rs2 tag `{1,5}` while `cdb_valid[1]`, rob 5, val 0xDEAD → `out_valid` two cycles later with `out_val2`=0xDEAD.
- **Backpressure:** two ready entries, `out_ready`=0 for 3 cycles → payload and `out_valid` stable, `count` stays 1. Release → second entry appears on the next cycle.
- **Full boundary:** fill `DEPTH`-1 entries with pending tags. `full` rises when `issue_valid` is asserted for the last entry. `count`=`DEPTH`, and a further issue is dropped.
- **Rollback:** 5 busy entries, `out_valid`=1, rollback and an issue in the same cycle → next cycle `count`=0, `out_valid`=0, and no dispatch afterwards.
- **Dual CDB:** both channels carry rob 2 (val 0x11 on channel 0, 0x22 on channel 1), plus `rdy` low for 2 cycles mid-test → the entry captures 0x11, and there is no state change while `rdy`=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared reservation-station constants: operand tag layout, decoder/ALU field
// widths and the "no position" marker used by the slot selectors.
package rs_pkg;

  // Default ROB position width used across the core.
  localparam int RS_ROB_POS_W = 4;

  // Operand tag is one pending bit on top of a ROB position.
  function automatic int tag_w(input int rob_pos_w);
    return rob_pos_w + 1;
  endfunction

  // The pending bit is the tag MSB.
  function automatic int tag_pend_bit(input int rob_pos_w);
    return rob_pos_w;
  endfunction

  localparam int TAG_W        = tag_w(RS_ROB_POS_W);
  localparam int TAG_PEND_BIT = tag_pend_bit(RS_ROB_POS_W);

  // Instruction field widths shared with the decoder and the ALU.
  localparam int OPCODE_W = 7;
  localparam int FUNC3_W  = 3;

  // Marker for a selector that found no candidate slot.
  localparam int NO_POS = -1;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: given the ready vector and the age matrix
// (older[e][j] = 1 when entry j is older than entry e) it grants the one
// ready entry that has no older ready entry.
module rs_age_select
  import rs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        any
);

  // Grant every ready entry that sees no ready entry older than itself.
  always_comb begin
    grant = {DEPTH{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      grant[e] = ready[e] && ((older[e] & ready) == {DEPTH{1'b0}});
    end
    any = |grant;
  end

endmodule

// File: rtl/rs_age_queue.sv
// Reservation station with CDB snooping, issue bypass and oldest-first
// dispatch to the ALU over a registered valid/ready output stage.
module rs_age_queue
  import rs_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ROB_POS_W = RS_ROB_POS_W,
  parameter int DATA_W    = 32,
  parameter int N_CDB     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rollback,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic                        issue_valid,
  input  logic [ROB_POS_W-1:0]        issue_rob_pos,
  input  logic [OPCODE_W-1:0]         issue_opcode,
  input  logic [FUNC3_W-1:0]          issue_func3,
  input  logic                        issue_func1,
  input  logic [DATA_W-1:0]           issue_rs1_val,
  input  logic [DATA_W-1:0]           issue_rs2_val,
  input  logic [DATA_W-1:0]           issue_imm,
  input  logic [DATA_W-1:0]           issue_pc,
  input  logic [ROB_POS_W:0]          issue_rs1_tag,
  input  logic [ROB_POS_W:0]          issue_rs2_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OPCODE_W-1:0]         out_opcode,
  output logic [FUNC3_W-1:0]          out_func3,
  output logic                        out_func1,
  output logic [DATA_W-1:0]           out_val1,
  output logic [DATA_W-1:0]           out_val2,
  output logic [DATA_W-1:0]           out_imm,
  output logic [DATA_W-1:0]           out_pc,
  output logic [ROB_POS_W-1:0]        out_rob_pos,
  input  logic [N_CDB-1:0]            cdb_valid,
  input  logic [N_CDB*ROB_POS_W-1:0]  cdb_rob_pos,
  input  logic [N_CDB*DATA_W-1:0]     cdb_val
);

  localparam int TW    = tag_w(ROB_POS_W);
  localparam int PEND  = tag_pend_bit(ROB_POS_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Per-entry storage
  logic [DEPTH-1:0]            busy_r;
  logic [CNT_W-1:0]            count_r;
  logic [DEPTH-1:0][DEPTH-1:0] older_r;
  logic [OPCODE_W-1:0]         opcode_r  [DEPTH];
  logic [FUNC3_W-1:0]          func3_r   [DEPTH];
  logic                        func1_r   [DEPTH];
  logic [TW-1:0]               tag1_r    [DEPTH];
  logic [TW-1:0]               tag2_r    [DEPTH];
  logic [DATA_W-1:0]           val1_r    [DEPTH];
  logic [DATA_W-1:0]           val2_r    [DEPTH];
  logic [DATA_W-1:0]           imm_r     [DEPTH];
  logic [DATA_W-1:0]           pc_r      [DEPTH];
  logic [ROB_POS_W-1:0]        rob_pos_r [DEPTH];

  // Control and datapath helpers
  int                          free_idx_s;
  logic                        issue_acc_s;
  logic [DEPTH-1:0]            issue_mask_s;
  logic [DEPTH-1:0]            ready_s;
  logic [DEPTH-1:0]            grant_s;
  logic                        any_s;
  logic                        dispatch_s;
  logic [DEPTH-1:0]            disp_mask_s;
  logic [DEPTH-1:0]            busy_n_s;
  logic [CNT_W-1:0]            count_n_s;
  logic [DATA_W:0]             wake1_s [DEPTH];
  logic [DATA_W:0]             wake2_s [DEPTH];
  logic [DATA_W:0]             byp1_s;
  logic [DATA_W:0]             byp2_s;
  logic [OPCODE_W-1:0]         sel_opcode_s;
  logic [FUNC3_W-1:0]          sel_func3_s;
  logic                        sel_func1_s;
  logic [DATA_W-1:0]           sel_val1_s;
  logic [DATA_W-1:0]           sel_val2_s;
  logic [DATA_W-1:0]           sel_imm_s;
  logic [DATA_W-1:0]           sel_pc_s;
  logic [ROB_POS_W-1:0]        sel_rob_pos_s;

  // Lowest-index clear bit of the busy vector, or NO_POS when all are busy.
  function automatic int lowest_free(input logic [DEPTH-1:0] busy);
    int idx;
    idx = NO_POS;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Returns {hit, value} for a pending tag against the CDB; the lowest
  // channel wins because it is visited last.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TW-1:0]               tag,
    input logic [N_CDB-1:0]            vld,
    input logic [N_CDB*ROB_POS_W-1:0]  pos,
    input logic [N_CDB*DATA_W-1:0]     val
  );
    logic [DATA_W:0] res;
    res = {(DATA_W + 1){1'b0}};
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tag[PEND] && (tag[ROB_POS_W-1:0] == pos[k*ROB_POS_W +: ROB_POS_W])) begin
        res = {1'b1, val[k*DATA_W +: DATA_W]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Free-slot choice, issue acceptance, ready vector and CDB compares.
  always_comb begin
    free_idx_s   = lowest_free(busy_r);
    issue_acc_s  = issue_valid && rdy && !rollback && (free_idx_s != NO_POS);
    issue_mask_s = {DEPTH{1'b0}};
    ready_s      = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      issue_mask_s[i] = issue_acc_s && (i == free_idx_s);
      ready_s[i]      = busy_r[i] && !tag1_r[i][PEND] && !tag2_r[i][PEND];
      wake1_s[i]      = cdb_lookup(tag1_r[i], cdb_valid, cdb_rob_pos, cdb_val);
      wake2_s[i]      = cdb_lookup(tag2_r[i], cdb_valid, cdb_rob_pos, cdb_val);
    end
    byp1_s = cdb_lookup(issue_rs1_tag, cdb_valid, cdb_rob_pos, cdb_val);
    byp2_s = cdb_lookup(issue_rs2_tag, cdb_valid, cdb_rob_pos, cdb_val);
  end

  rs_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .ready (ready_s),
    .older (older_r),
    .grant (grant_s),
    .any   (any_s)
  );

  // Dispatch decision and next busy/count values.
  always_comb begin
    dispatch_s  = any_s && (!out_valid || out_ready) && rdy && !rollback;
    disp_mask_s = dispatch_s ? grant_s : {DEPTH{1'b0}};
    busy_n_s    = (busy_r & ~disp_mask_s) | issue_mask_s;
    count_n_s   = count_r + CNT_W'(issue_acc_s) - CNT_W'(dispatch_s);
  end

  // One-hot OR mux of the granted entry's payload.
  always_comb begin
    sel_opcode_s  = {OPCODE_W{1'b0}};
    sel_func3_s   = {FUNC3_W{1'b0}};
    sel_func1_s   = 1'b0;
    sel_val1_s    = {DATA_W{1'b0}};
    sel_val2_s    = {DATA_W{1'b0}};
    sel_imm_s     = {DATA_W{1'b0}};
    sel_pc_s      = {DATA_W{1'b0}};
    sel_rob_pos_s = {ROB_POS_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sel_opcode_s  = sel_opcode_s  | ({OPCODE_W{grant_s[i]}}  & opcode_r[i]);
      sel_func3_s   = sel_func3_s   | ({FUNC3_W{grant_s[i]}}   & func3_r[i]);
      sel_func1_s   = sel_func1_s   | (grant_s[i] & func1_r[i]);
      sel_val1_s    = sel_val1_s    | ({DATA_W{grant_s[i]}}    & val1_r[i]);
      sel_val2_s    = sel_val2_s    | ({DATA_W{grant_s[i]}}    & val2_r[i]);
      sel_imm_s     = sel_imm_s     | ({DATA_W{grant_s[i]}}    & imm_r[i]);
      sel_pc_s      = sel_pc_s      | ({DATA_W{grant_s[i]}}    & pc_r[i]);
      sel_rob_pos_s = sel_rob_pos_s | ({ROB_POS_W{grant_s[i]}} & rob_pos_r[i]);
    end
  end

  assign full  = (count_r == CNT_W'(DEPTH)) ||
                 ((count_r == CNT_W'(DEPTH - 1)) && issue_valid);
  assign count = count_r;

  // Busy bits, occupancy count and age matrix; a new entry is younger than
  // everything still busy, so its row copies busy and its column is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      older_r <= {(DEPTH * DEPTH){1'b0}};
    end else if (rdy && rollback) begin
      busy_r  <= {DEPTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      older_r <= {(DEPTH * DEPTH){1'b0}};
    end else if (rdy) begin
      busy_r  <= busy_n_s;
      count_r <= count_n_s;
      for (int r = 0; r < DEPTH; r++) begin
        if (issue_mask_s[r]) begin
          older_r[r] <= busy_r & ~disp_mask_s;
        end else begin
          older_r[r] <= older_r[r] & ~issue_mask_s;
        end
      end
    end
  end

  // Entry payload: fill on issue (with CDB bypass), else wake pending operands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_mask_s[i]) begin
        opcode_r[i]  <= issue_opcode;
        func3_r[i]   <= issue_func3;
        func1_r[i]   <= issue_func1;
        imm_r[i]     <= issue_imm;
        pc_r[i]      <= issue_pc;
        rob_pos_r[i] <= issue_rob_pos;
        if (byp1_s[DATA_W]) begin
          tag1_r[i] <= {TW{1'b0}};
          val1_r[i] <= byp1_s[DATA_W-1:0];
        end else begin
          tag1_r[i] <= issue_rs1_tag;
          val1_r[i] <= issue_rs1_val;
        end
        if (byp2_s[DATA_W]) begin
          tag2_r[i] <= {TW{1'b0}};
          val2_r[i] <= byp2_s[DATA_W-1:0];
        end else begin
          tag2_r[i] <= issue_rs2_tag;
          val2_r[i] <= issue_rs2_val;
        end
      end else if (rdy && !rollback && !rst && busy_r[i]) begin
        if (wake1_s[i][DATA_W]) begin
          tag1_r[i] <= {TW{1'b0}};
          val1_r[i] <= wake1_s[i][DATA_W-1:0];
        end
        if (wake2_s[i][DATA_W]) begin
          tag2_r[i] <= {TW{1'b0}};
          val2_r[i] <= wake2_s[i][DATA_W-1:0];
        end
      end
    end
  end

  // Registered dispatch stage: load on dispatch, drain on ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_opcode  <= {OPCODE_W{1'b0}};
      out_func3   <= {FUNC3_W{1'b0}};
      out_func1   <= 1'b0;
      out_val1    <= {DATA_W{1'b0}};
      out_val2    <= {DATA_W{1'b0}};
      out_imm     <= {DATA_W{1'b0}};
      out_pc      <= {DATA_W{1'b0}};
      out_rob_pos <= {ROB_POS_W{1'b0}};
    end else if (rdy && rollback) begin
      out_valid <= 1'b0;
    end else if (dispatch_s) begin
      out_valid   <= 1'b1;
      out_opcode  <= sel_opcode_s;
      out_func3   <= sel_func3_s;
      out_func1   <= sel_func1_s;
      out_val1    <= sel_val1_s;
      out_val2    <= sel_val2_s;
      out_imm     <= sel_imm_s;
      out_pc      <= sel_pc_s;
      out_rob_pos <= sel_rob_pos_s;
    end else if (rdy && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_age_queue.sv
// Self-checking bench for rs_age_queue: directed scenarios plus random
// traffic, all compared against an age-ordered queue model.
module tb_rs_age_queue;

  localparam int DEPTH = 16;
  localparam int RPW   = 4;
  localparam int DW    = 32;
  localparam int NC    = 2;

  logic            clk = 1'b0;
  logic            rst, rdy, rollback, full, issue_valid, issue_func1, out_valid, out_ready;
  logic [4:0]      count;
  logic [RPW-1:0]  issue_rob_pos, out_rob_pos;
  logic [6:0]      issue_opcode, out_opcode;
  logic [2:0]      issue_func3, out_func3;
  logic            out_func1;
  logic [DW-1:0]   issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [RPW:0]    issue_rs1_tag, issue_rs2_tag;
  logic [DW-1:0]   out_val1, out_val2, out_imm, out_pc;
  logic [NC-1:0]   cdb_valid;
  logic [NC*RPW-1:0] cdb_rob_pos;
  logic [NC*DW-1:0]  cdb_val;

  always #5 clk = ~clk;

  rs_age_queue #(.DEPTH(DEPTH), .ROB_POS_W(RPW), .DATA_W(DW), .N_CDB(NC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .full(full), .count(count),
    .issue_valid(issue_valid), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
    .issue_func3(issue_func3), .issue_func1(issue_func1), .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func1(out_func1), .out_val1(out_val1), .out_val2(out_val2),
    .out_imm(out_imm), .out_pc(out_pc), .out_rob_pos(out_rob_pos),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val)
  );

  // Reference model: entries kept oldest-first in a queue.
  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f1;
    logic [4:0]  t1, t2;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0]  rob;
  } ent_t;

  ent_t         q[$];
  logic         m_ov;
  logic [142:0] m_pay;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand capture from the CDB: first matching channel wins.
  function automatic void wake(input logic [4:0] t, input logic [31:0] v,
                               output logic [4:0] to, output logic [31:0] vo);
    to = t;
    vo = v;
    for (int k = 0; k < NC; k++) begin
      if (t[4] && cdb_valid[k] && (t[3:0] == cdb_rob_pos[k*RPW +: RPW])) begin
        to = 5'd0;
        vo = cdb_val[k*DW +: DW];
        break;
      end
    end
  endfunction

  function automatic logic m_full();
    int fr;
    fr = DEPTH - q.size();
    return (fr == 0) || (fr == 1 && issue_valid);
  endfunction

  task automatic model_step();
    int sel, pre;
    bit do_disp;
    ent_t d, e;
    logic [4:0] t;
    logic [31:0] v;
    if (rst) begin
      q.delete();
      m_ov  = 1'b0;
      m_pay = '0;
    end else if (rdy && rollback) begin
      q.delete();
      m_ov = 1'b0;
    end else if (rdy) begin
      pre = q.size();
      sel = -1;
      foreach (q[i]) if (sel < 0 && !q[i].t1[4] && !q[i].t2[4]) sel = i;
      do_disp = (sel >= 0) && (!m_ov || out_ready);
      if (do_disp) d = q[sel];
      foreach (q[i]) begin
        wake(q[i].t1, q[i].v1, t, v); q[i].t1 = t; q[i].v1 = v;
        wake(q[i].t2, q[i].v2, t, v); q[i].t2 = t; q[i].v2 = v;
      end
      if (do_disp) q.delete(sel);
      if (issue_valid && pre < DEPTH) begin
        e.opc = issue_opcode; e.f3 = issue_func3; e.f1 = issue_func1;
        e.imm = issue_imm; e.pc = issue_pc; e.rob = issue_rob_pos;
        wake(issue_rs1_tag, issue_rs1_val, e.t1, e.v1);
        wake(issue_rs2_tag, issue_rs2_val, e.t2, e.v2);
        q.push_back(e);
      end
      if (do_disp) begin
        m_ov  = 1'b1;
        m_pay = {d.opc, d.f3, d.f1, d.v1, d.v2, d.imm, d.pc, d.rob};
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // One clock: check full on the live inputs, advance, then check outputs.
  task automatic tick();
    logic [142:0] pay;
    #1;
    if (!rst) chk("full", 160'(full), 160'(m_full()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    pay = {out_opcode, out_func3, out_func1, out_val1, out_val2, out_imm, out_pc, out_rob_pos};
    chk("out_valid", 160'(out_valid), 160'(m_ov));
    chk("count", 160'(count), 160'(q.size()));
    chk("payload", 160'(pay), 160'(m_pay));
  endtask

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic set_issue(input logic [3:0] rob, input logic [4:0] t1, input logic [31:0] v1,
                           input logic [4:0] t2, input logic [31:0] v2);
    issue_valid = 1'b1; issue_rob_pos = rob;
    issue_rs1_tag = t1; issue_rs1_val = v1; issue_rs2_tag = t2; issue_rs2_val = v2;
    issue_opcode = 7'($urandom); issue_func3 = 3'($urandom); issue_func1 = 1'($urandom);
    issue_imm = $urandom; issue_pc = $urandom;
  endtask

  task automatic set_cdb(input int ch, input logic [3:0] rob, input logic [31:0] v);
    cdb_valid[ch] = 1'b1;
    cdb_rob_pos[ch*RPW +: RPW] = rob;
    cdb_val[ch*DW +: DW] = v;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; cdb_rob_pos = '0; cdb_val = '0;
    idle();
    set_issue(4'd0, 5'h00, 32'd0, 5'h00, 32'd0);
    issue_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_full", 160'(full), 160'(1'b0));

    // Oldest-first: A waits on ROB 3, B and C ready.
    out_ready = 1'b1;
    idle(); set_issue(4'd1, 5'h13, 32'h0, 5'h00, 32'h7); tick();
    idle(); set_issue(4'd2, 5'h00, 32'h1, 5'h00, 32'h2); tick();
    idle(); set_issue(4'd4, 5'h00, 32'h3, 5'h00, 32'h4); tick();
    chk("ord_B", 160'(out_rob_pos), 160'(4'd2));
    idle(); set_cdb(0, 4'd3, 32'h55); tick();
    chk("ord_C", 160'(out_rob_pos), 160'(4'd4));
    idle(); tick();
    chk("ord_A", 160'(out_rob_pos), 160'(4'd1));
    chk("A_val1", 160'(out_val1), 160'(32'h55));
    idle(); tick();

    // Issue bypass from CDB channel 1.
    idle(); set_issue(4'd6, 5'h00, 32'h1, 5'h15, 32'h0); set_cdb(1, 4'd5, 32'hDEAD); tick();
    idle(); tick();
    chk("byp_valid", 160'(out_valid), 160'(1'b1));
    chk("byp_val2", 160'(out_val2), 160'(32'hDEAD));
    idle(); tick();

    // Backpressure.
    out_ready = 1'b0;
    idle(); set_issue(4'd7, 5'h00, 32'h1, 5'h00, 32'h2); tick();
    idle(); set_issue(4'd8, 5'h00, 32'h3, 5'h00, 32'h4); tick();
    chk("bp_first", 160'(out_rob_pos), 160'(4'd7));
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", 160'(out_rob_pos), 160'(4'd7));
      chk("bp_cnt", 160'(count), 160'(5'd1));
    end
    out_ready = 1'b1; tick();
    chk("bp_second", 160'(out_rob_pos), 160'(4'd8));
    idle(); tick();

    // Full boundary with pending entries.
    for (int i = 0; i < DEPTH - 1; i++) begin
      idle(); set_issue(4'(i), 5'h17, 32'h0, 5'h00, 32'h0); tick();
    end
    idle(); #1;
    chk("full_idle", 160'(full), 160'(1'b0));
    set_issue(4'd15, 5'h17, 32'h0, 5'h00, 32'h0); #1;
    chk("full_last", 160'(full), 160'(1'b1));
    tick();
    chk("full_cnt", 160'(count), 160'(5'd16));
    set_issue(4'd14, 5'h00, 32'h0, 5'h00, 32'h0); tick();
    chk("full_drop", 160'(count), 160'(5'd16));
    idle(); rollback = 1'b1; tick();

    // Rollback with a same-cycle issue.
    out_ready = 1'b0;
    idle(); set_issue(4'd1, 5'h00, 32'h1, 5'h00, 32'h1); tick();
    for (int i = 0; i < 5; i++) begin
      idle(); set_issue(4'(i + 2), 5'h17, 32'h0, 5'h00, 32'h0); tick();
    end
    chk("rb_pre_cnt", 160'(count), 160'(5'd5));
    chk("rb_pre_ov", 160'(out_valid), 160'(1'b1));
    idle(); rollback = 1'b1; set_issue(4'd9, 5'h00, 32'h0, 5'h00, 32'h0); tick();
    chk("rb_cnt", 160'(count), 160'(5'd0));
    chk("rb_ov", 160'(out_valid), 160'(1'b0));
    idle(); out_ready = 1'b1; set_cdb(0, 4'd7, 32'h1); tick();
    idle(); tick();
    chk("rb_nodisp", 160'(out_valid), 160'(1'b0));

    // Dual CDB on the same ROB position, with rdy low in the middle.
    idle(); set_issue(4'd9, 5'h12, 32'h0, 5'h00, 32'h3); tick();
    idle(); rdy = 1'b0; set_cdb(0, 4'd2, 32'h99); set_issue(4'd3, 5'h00, 32'h0, 5'h00, 32'h0);
    tick(); tick();
    chk("rdy_cnt", 160'(count), 160'(5'd1));
    idle(); set_cdb(0, 4'd2, 32'h11); set_cdb(1, 4'd2, 32'h22); tick();
    idle(); tick();
    chk("dual_val1", 160'(out_val1), 160'(32'h11));
    idle(); tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy       = ($urandom % 10) != 0;
      rollback  = ($urandom % 150) == 0;
      out_ready = ($urandom % 3) != 0;
      if (($urandom % 3) != 0)
        set_issue(4'($urandom), ($urandom % 2) ? {1'b1, 4'($urandom_range(0, 7))} : 5'h00, $urandom,
                  ($urandom % 2) ? {1'b1, 4'($urandom_range(0, 7))} : 5'h00, $urandom);
      else
        issue_valid = 1'b0;
      cdb_valid = '0;
      for (int k = 0; k < NC; k++)
        if (($urandom % 3) == 0) set_cdb(k, 4'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
